// File: rtl/hazard_md_ctrl.sv
// Central stall/flush controller: Tuse/Tnew RAW hazard detection against the
// ID/EX and EX/MEM producers, mult/div busy sequencing and a stall counter.
module hazard_md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic        rs_read_d,
    input  logic        rt_read_d,
    input  logic [1:0]  rs_tuse_d,
    input  logic [1:0]  rt_tuse_d,
    input  logic [4:0]  a3_e,
    input  logic [1:0]  tnew_e,
    input  logic [4:0]  a3_m,
    input  logic [1:0]  tnew_m,
    input  logic        md_use_d,
    input  logic        md_start_e,
    input  logic        md_is_div_e,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_e,
    output logic        md_busy,
    output logic [31:0] stall_count
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] md_count;
    logic             stall_rs;
    logic             stall_rt;
    logic             stall_md;
    logic             stall;
    logic             md_load;

    assign md_busy = (md_count != '0);

    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        if (rs_read_d && rs_d != 5'd0) begin
            if ((rs_d == a3_e && rs_tuse_d < tnew_e) || (rs_d == a3_m && rs_tuse_d < tnew_m))
                stall_rs = 1'b1;
        end
        if (rt_read_d && rt_d != 5'd0) begin
            if ((rt_d == a3_e && rt_tuse_d < tnew_e) || (rt_d == a3_m && rt_tuse_d < tnew_m))
                stall_rt = 1'b1;
        end
    end

    assign stall_md = md_use_d && (md_busy || md_start_e);
    assign stall    = !reset && (stall_rs || stall_rt || stall_md);
    assign stall_f  = stall;
    assign stall_d  = stall;
    assign flush_e  = stall;

    // A start is accepted when idle or on the final busy cycle, giving back-to-back ops no gap.
    assign md_load = md_start_e && (md_count <= CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_count <= '0;
        end else if (md_load) begin
            md_count <= md_is_div_e ? DIV_LOAD : MULT_LOAD;
        end else if (md_count != '0) begin
            md_count <= md_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && stall_count != 32'hFFFF_FFFF) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Self-checking bench for hazard_md_ctrl: table vectors, hand-written md
// sequences and randomized stimulus against a cycle-indexed reference model.
module tb_hazard_md_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_d, rt_d, a3_e, a3_m;
    logic        rs_read_d, rt_read_d;
    logic [1:0]  rs_tuse_d, rt_tuse_d, tnew_e, tnew_m;
    logic        md_use_d, md_start_e, md_is_div_e;
    logic        stall_f, stall_d, flush_e, md_busy;
    logic [31:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: cycle index and last cycle the md unit is busy
    int          cyc        = 0;
    int          busy_until = -1;
    logic [31:0] m_count    = 0;
    logic        s_stall, s_busy;
    logic [31:0] s_count;

    always #5 clk = ~clk;

    hazard_md_ctrl dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .rs_read_d(rs_read_d), .rt_read_d(rt_read_d),
        .rs_tuse_d(rs_tuse_d), .rt_tuse_d(rt_tuse_d),
        .a3_e(a3_e), .tnew_e(tnew_e), .a3_m(a3_m), .tnew_m(tnew_m),
        .md_use_d(md_use_d), .md_start_e(md_start_e), .md_is_div_e(md_is_div_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .md_busy(md_busy), .stall_count(stall_count)
    );

    typedef struct {
        logic [4:0] rs, rt, a3e, a3m;
        logic       rsr, rtr;
        logic [1:0] rsu, rtu, tne, tnm;
        logic       exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // A source must wait while any matching producer needs more cycles than the consumer has.
    function automatic bit src_waits(input logic rd, input logic [4:0] src, input logic [1:0] tuse);
        logic [4:0] dst[2];
        logic [1:0] tn[2];
        dst[0] = a3_e; tn[0] = tnew_e;
        dst[1] = a3_m; tn[1] = tnew_m;
        if (!rd || src == 0) return 1'b0;
        for (int p = 0; p < 2; p++)
            if (dst[p] == src && int'(tn[p]) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_inputs();
        reset = 0; rs_d = 0; rt_d = 0; rs_read_d = 0; rt_read_d = 0;
        rs_tuse_d = 0; rt_tuse_d = 0; a3_e = 0; tnew_e = 0; a3_m = 0; tnew_m = 0;
        md_use_d = 0; md_start_e = 0; md_is_div_e = 0;
    endtask

    // Inputs are set after a negedge; sample, compare, advance the model, go to next negedge.
    task automatic tick_check();
        bit busy, exp_stall;
        #1;
        busy      = (cyc <= busy_until);
        exp_stall = !reset && (src_waits(rs_read_d, rs_d, rs_tuse_d) ||
                               src_waits(rt_read_d, rt_d, rt_tuse_d) ||
                               (md_use_d && (busy || md_start_e)));
        s_stall = stall_f; s_busy = md_busy; s_count = stall_count;
        check("stall_f", 32'(stall_f), 32'(exp_stall));
        check("stall_d", 32'(stall_d), 32'(exp_stall));
        check("flush_e", 32'(flush_e), 32'(exp_stall));
        check("md_busy", 32'(md_busy), 32'(busy));
        check("stall_count", stall_count, m_count);
        if (reset) begin
            busy_until = cyc;
            m_count    = 0;
        end else begin
            if (md_start_e && (!busy || busy_until == cyc))
                busy_until = cyc + (md_is_div_e ? 10 : 5);
            if (exp_stall && m_count != 32'hFFFF_FFFF) m_count++;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{rs:8, rt:0, a3e:8, a3m:0, rsr:1, rtr:0, rsu:0, rtu:0, tne:1, tnm:0, exp:1};
        vecs[1] = '{rs:8, rt:0, a3e:0, a3m:0, rsr:1, rtr:0, rsu:0, rtu:0, tne:1, tnm:0, exp:0};
        vecs[2] = '{rs:0, rt:0, a3e:0, a3m:0, rsr:1, rtr:1, rsu:0, rtu:0, tne:2, tnm:2, exp:0};
        vecs[3] = '{rs:8, rt:0, a3e:8, a3m:0, rsr:1, rtr:0, rsu:1, rtu:0, tne:1, tnm:0, exp:0};
        vecs[4] = '{rs:0, rt:9, a3e:0, a3m:9, rsr:0, rtr:1, rsu:0, rtu:1, tne:0, tnm:2, exp:1};
        vecs[5] = '{rs:0, rt:9, a3e:0, a3m:9, rsr:0, rtr:0, rsu:0, rtu:1, tne:0, tnm:2, exp:0};
        vecs[6] = '{rs:5, rt:0, a3e:5, a3m:0, rsr:1, rtr:0, rsu:2, rtu:0, tne:2, tnm:0, exp:0};
        vecs[7] = '{rs:3, rt:0, a3e:0, a3m:3, rsr:1, rtr:0, rsu:0, rtu:0, tne:0, tnm:1, exp:1};
        vecs[8] = '{rs:0, rt:7, a3e:7, a3m:0, rsr:0, rtr:1, rsu:0, rtu:0, tne:0, tnm:0, exp:0};

        clear_inputs();
        reset = 1;
        @(negedge clk); @(negedge clk);
        tick_check();                       // reset held: outputs forced low, state cleared
        reset = 0;

        // lw in E then M: one stall cycle
        clear_inputs();
        rs_d = 8; rs_read_d = 1; rs_tuse_d = 1; a3_e = 8; tnew_e = 2;
        tick_check();
        check("lw_stall_e", 32'(s_stall), 1);
        a3_e = 0; tnew_e = 0; a3_m = 8; tnew_m = 1;
        tick_check();
        check("lw_stall_m", 32'(s_stall), 0);
        clear_inputs();
        tick_check();
        check("lw_count", s_count, 1);

        foreach (vecs[i]) begin
            clear_inputs();
            rs_d = vecs[i].rs; rt_d = vecs[i].rt; rs_read_d = vecs[i].rsr; rt_read_d = vecs[i].rtr;
            rs_tuse_d = vecs[i].rsu; rt_tuse_d = vecs[i].rtu;
            a3_e = vecs[i].a3e; tnew_e = vecs[i].tne; a3_m = vecs[i].a3m; tnew_m = vecs[i].tnm;
            tick_check();
            check($sformatf("vec%0d_stall", i), 32'(s_stall), 32'(vecs[i].exp));
        end

        // mult start with mflo waiting in D
        clear_inputs();
        for (int i = 0; i < 8; i++) begin
            md_use_d = 1; md_start_e = (i == 0);
            tick_check();
            check("mult_stall", 32'(s_stall), 32'(i <= 5));
            check("mult_busy", 32'(s_busy), 32'(i >= 1 && i <= 5));
        end

        // div start, illegal second start mid-busy is ignored
        clear_inputs();
        for (int i = 0; i < 13; i++) begin
            md_start_e = (i == 0 || i == 4); md_is_div_e = 1;
            tick_check();
            check("div_busy", 32'(s_busy), 32'(i >= 1 && i <= 10));
        end

        // back-to-back: second mult issued on the final busy cycle
        clear_inputs();
        for (int i = 0; i < 13; i++) begin
            md_start_e = (i == 0 || i == 5);
            tick_check();
            check("b2b_busy", 32'(s_busy), 32'(i >= 1 && i <= 10));
        end

        // reset while a div is in flight (count==3 at step 8)
        clear_inputs();
        for (int i = 0; i < 10; i++) begin
            md_start_e = (i == 0); md_is_div_e = 1; md_use_d = 1;
            reset = (i == 8);
            if (i == 8) begin rs_d = 4; rs_read_d = 1; a3_e = 4; tnew_e = 2; end
            tick_check();
            if (i == 8) check("rst_stall_low", 32'(s_stall), 0);
            if (i == 9) begin
                check("rst_busy", 32'(s_busy), 0);
                check("rst_count", s_count, 0);
            end
        end

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(99) == 0);
            rs_d        = 5'($urandom_range(3));
            rt_d        = 5'($urandom_range(3));
            rs_read_d   = 1'($urandom);
            rt_read_d   = 1'($urandom);
            rs_tuse_d   = 2'($urandom);
            rt_tuse_d   = 2'($urandom);
            a3_e        = 5'($urandom_range(3));
            a3_m        = 5'($urandom_range(3));
            tnew_e      = 2'($urandom);
            tnew_m      = 2'($urandom);
            md_use_d    = ($urandom_range(2) == 0);
            md_start_e  = ($urandom_range(5) == 0);
            md_is_div_e = 1'($urandom);
            tick_check();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
